// File: rtl/disp_pkg.sv
// Shared types and constants for the scrolling hex-display sequencer.
package disp_pkg;
  localparam logic [3:0] HEX_BLANK  = 4'hc;
  localparam logic       DP_OFF     = 1'b1;
  localparam int         NUM_DIGITS = 4;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} scroll_state_t;

  typedef struct packed {
    logic [3:0] code;
    logic       dp;
  } disp_char_t;

  localparam disp_char_t BLANK_CHAR = '{code: HEX_BLANK, dp: DP_OFF};
endpackage

// File: rtl/disp_scroll_ctrl_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV enabled cycles; count freezes while en is low.
module tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else if (en)          cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/disp_scroll_ctrl.sv
// Scrolls a buffered message right-to-left across a 4-digit hex display.
module disp_scroll_ctrl
  import disp_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int TICK_DIV = 25_000_000,
  parameter int LOOPS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic [4:0] msg_len,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] dp_out,
  output logic       busy,
  output logic       done
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int PW = (LOOPS < 2) ? 1 : $clog2(LOOPS + 1);

  scroll_state_t state, state_nxt;
  logic [4:0]    len, len_nxt;
  logic [4:0]    pos, pos_nxt;
  logic [PW-1:0] passes, passes_nxt;
  logic          done_nxt, done_q;
  logic          tick, clr, start_ok, last_pass;
  logic [5:0]    strm_len;

  disp_char_t                  msg_buf [MAX_LEN];
  disp_char_t [NUM_DIGITS-1:0] win;
  logic [NUM_DIGITS-1:0][3:0]  hex_q;
  logic [NUM_DIGITS-1:0]       dp_q;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (state == RUN && !hold),
    .tick (tick)
  );

  assign start_ok  = start && (msg_len != 5'd0) && (msg_len <= 5'(MAX_LEN));
  assign last_pass = (LOOPS != 0) && ((PW+1)'(passes) + 1'b1 == (PW+1)'(LOOPS));

  // stop outranks start; start (restart) outranks a coincident tick
  always_comb begin
    state_nxt  = state;
    len_nxt    = len;
    pos_nxt    = pos;
    passes_nxt = passes;
    done_nxt   = 1'b0;
    clr        = 1'b0;
    if (stop) begin
      if (state == RUN) begin
        state_nxt = IDLE;
        pos_nxt   = '0;
      end
    end else if (start_ok) begin
      state_nxt  = RUN;
      len_nxt    = msg_len;
      pos_nxt    = '0;
      passes_nxt = '0;
      clr        = 1'b1;
    end else if (state == RUN && tick) begin
      if (6'(pos) == 6'(len) + 6'd3) begin
        pos_nxt = '0;
        if (last_pass) begin
          state_nxt  = IDLE;
          passes_nxt = '0;
          done_nxt   = 1'b1;
        end else begin
          passes_nxt = passes + 1'b1;
        end
      end else begin
        pos_nxt = pos + 1'b1;
      end
    end
  end

  // Window is built from next-cycle pos so outputs move together with busy/done.
  assign strm_len = 6'(len_nxt) + 6'd4;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [5:0] idx_raw, idx;
    logic [5:0] rel;
    disp_char_t ch;
    always_comb begin
      idx_raw = 6'(pos_nxt) + 6'(NUM_DIGITS - 1 - k);
      idx     = (idx_raw >= strm_len) ? idx_raw - strm_len : idx_raw;
      rel     = idx - 6'd4;
      ch      = BLANK_CHAR;
      if (state_nxt == RUN && idx >= 6'd4) ch = msg_buf[rel[AW-1:0]];
    end
    assign win[k] = ch;
  end

  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < 5'(MAX_LEN)))
      msg_buf[wr_addr[AW-1:0]] <= '{code: wr_data, dp: wr_dp};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      len    <= '0;
      pos    <= '0;
      passes <= '0;
      done_q <= 1'b0;
      hex_q  <= {NUM_DIGITS{HEX_BLANK}};
      dp_q   <= {NUM_DIGITS{DP_OFF}};
    end else begin
      state  <= state_nxt;
      len    <= len_nxt;
      pos    <= pos_nxt;
      passes <= passes_nxt;
      done_q <= done_nxt;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        hex_q[k] <= win[k].code;
        dp_q[k]  <= win[k].dp;
      end
    end
  end

  assign hex3   = hex_q[3];
  assign hex2   = hex_q[2];
  assign hex1   = hex_q[1];
  assign hex0   = hex_q[0];
  assign dp_out = dp_q;
  assign busy   = (state == RUN);
  assign done   = done_q;
endmodule

// File: tb/tb_disp_scroll_ctrl.sv
// Randomised scoreboard bench: LOOPS=1 and LOOPS=0 instances against a stream/window model.
module tb_disp_scroll_ctrl;
  localparam int ML = 16;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst, wr_en, wr_dp, start, stop, hold;
  logic [3:0] wr_addr, wr_data;
  logic [4:0] msg_len;

  logic [1:0][3:0][3:0] hx;
  logic [1:0][3:0]      dpo;
  logic [1:0]           bsy, dn;

  always #5 clk = ~clk;

  disp_scroll_ctrl #(.MAX_LEN(ML), .TICK_DIV(TD), .LOOPS(1)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dp(wr_dp), .msg_len(msg_len), .start(start), .stop(stop), .hold(hold),
    .hex3(hx[0][3]), .hex2(hx[0][2]), .hex1(hx[0][1]), .hex0(hx[0][0]),
    .dp_out(dpo[0]), .busy(bsy[0]), .done(dn[0]));

  disp_scroll_ctrl #(.MAX_LEN(ML), .TICK_DIV(TD), .LOOPS(0)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dp(wr_dp), .msg_len(msg_len), .start(start), .stop(stop), .hold(hold),
    .hex3(hx[1][3]), .hex2(hx[1][2]), .hex1(hx[1][1]), .hex0(hx[1][0]),
    .dp_out(dpo[1]), .busy(bsy[1]), .done(dn[1]));

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic        busy;
    logic        done;
  } obs_t;

  typedef struct packed {
    obs_t i1;
    obs_t i0;
  } exp_t;

  exp_t expq[$];

  // reference state: run flag, message length, scroll position, passes, cycles since last step
  bit         m_run  [2];
  int         m_len  [2];
  int         m_pos  [2];
  int         m_pass [2];
  int         m_cnt  [2];
  int         m_done_cnt [2];
  int         d_done_cnt [2];
  logic [4:0] mem [ML];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic step_model(input int i, input int loops, output obs_t o);
    int L, idx;
    logic [4:0] ch;
    o = '0;
    if (rst) begin
      m_run[i] = 0; m_pos[i] = 0; m_pass[i] = 0; m_cnt[i] = 0; m_len[i] = 0;
    end else if (stop) begin
      if (m_run[i]) begin m_run[i] = 0; m_pos[i] = 0; end
    end else if (start && msg_len >= 1 && msg_len <= ML) begin
      m_run[i] = 1; m_len[i] = msg_len; m_pos[i] = 0; m_pass[i] = 0; m_cnt[i] = 0;
    end else if (m_run[i] && !hold) begin
      m_cnt[i]++;
      if (m_cnt[i] == TD) begin
        m_cnt[i] = 0;
        m_pos[i] = (m_pos[i] + 1) % (m_len[i] + 4);
        if (m_pos[i] == 0) begin
          m_pass[i]++;
          if (loops != 0 && m_pass[i] == loops) begin
            m_run[i] = 0;
            o.done = 1'b1;
            m_done_cnt[i]++;
          end
        end
      end
    end
    o.busy = m_run[i];
    L = m_len[i] + 4;
    for (int k = 0; k < 4; k++) begin
      ch = {4'hc, 1'b1};
      if (m_run[i]) begin
        idx = (m_pos[i] + 3 - k) % L;
        if (idx >= 4) ch = mem[idx - 4];
      end
      o.hex[k*4 +: 4] = ch[4:1];
      o.dp[k]         = ch[0];
    end
  endtask

  task automatic cyc();
    exp_t e;
    obs_t a, b;
    @(posedge clk);
    step_model(0, 1, a);
    step_model(1, 0, b);
    if (wr_en) mem[wr_addr] = {wr_data, wr_dp};
    e.i0 = a;
    e.i1 = b;
    expq.push_back(e);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d, input logic p);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = p;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] l, input logic with_stop);
    start = 1'b1; stop = with_stop; msg_len = l;
    cyc();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got hex=%h dp=%h busy=%b done=%b, want hex=%h dp=%h busy=%b done=%b",
               name, $time, got.hex, got.dp, got.busy, got.done,
               exp.hex, exp.dp, exp.busy, exp.done);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("lp1", {hx[0], dpo[0], bsy[0], dn[0]}, e.i0);
      check("lp0", {hx[1], dpo[1], bsy[1], dn[1]}, e.i1);
      d_done_cnt[0] += int'(dn[0]);
      d_done_cnt[1] += int'(dn[1]);
    end
  end

  initial begin
    int r;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_dp = 1'b1;
    msg_len = '0; start = 1'b0; stop = 1'b0; hold = 1'b0;
    for (int i = 0; i < 2; i++) begin m_done_cnt[i] = 0; d_done_cnt[i] = 0; end
    repeat (2) cyc();
    rst = 1'b0;

    for (int a = 0; a < ML; a++) wr(4'(a), 4'($urandom_range(0, 12)), 1'($urandom));

    // "1234" with the '2' carrying an active decimal point
    wr(4'd0, 4'd1, 1'b1);
    wr(4'd1, 4'd2, 1'b0);
    wr(4'd2, 4'd3, 1'b1);
    wr(4'd3, 4'd4, 1'b1);
    pulse_start(5'd4, 1'b0);
    repeat (40) cyc();

    // stop at pos 3
    pulse_start(5'd4, 1'b0);
    repeat (13) cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    repeat (4) cyc();

    // start and stop together while idle
    pulse_start(5'd4, 1'b1);
    repeat (6) cyc();

    // hold at pos 5, then release; LOOPS=0 instance keeps cycling afterwards
    pulse_start(5'd4, 1'b0);
    repeat (20) cyc();
    hold = 1'b1; repeat (20) cyc(); hold = 1'b0;
    repeat (150) cyc();

    // invalid lengths, including from the running state
    pulse_start(5'd0, 1'b0);  repeat (3) cyc();
    pulse_start(5'd17, 1'b0); repeat (3) cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    pulse_start(5'd0, 1'b0);  repeat (3) cyc();
    pulse_start(5'd17, 1'b0); repeat (3) cyc();

    // full-length message and single-character message
    pulse_start(5'd16, 1'b0); repeat (90) cyc();
    pulse_start(5'd1, 1'b0);  repeat (25) cyc();

    for (int c = 0; c < 5000; c++) begin
      wr_en   = ($urandom % 8 == 0);
      wr_addr = 4'($urandom);
      wr_data = 4'($urandom_range(0, 12));
      wr_dp   = 1'($urandom);
      r       = $urandom % 200;
      start   = (r < 2) || (r == 3);
      stop    = (r == 2) || (r == 3);
      case ($urandom % 8)
        0:       msg_len = 5'd0;
        1:       msg_len = 5'd17;
        2:       msg_len = 5'd16;
        default: msg_len = 5'($urandom_range(1, 16));
      endcase
      if ($urandom % 60 == 0) hold = ~hold;
      rst = ($urandom % 1500 == 0);
      cyc();
      start = 1'b0; stop = 1'b0; wr_en = 1'b0; rst = 1'b0;
    end
    hold = 1'b0;
    repeat (3) cyc();

    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", expq.size());
    end
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (d_done_cnt[i] != m_done_cnt[i]) begin
        n_fail++;
        $display("FAIL done_count%0d: got %0d, want %0d", i, d_done_cnt[i], m_done_cnt[i]);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
